// File: rtl/mem_bridge.sv
// mem_bridge: three-state bridge between a core's data-access port and a
// single-outstanding, ack-based memory bus. Aligned accesses go to memory
// and wait for mack, or abort after TIMEOUT busy cycles. Misaligned
// accesses are rejected without touching the bus. Misaligned accesses and
// timeouts set the sticky buserr flag.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   MemStrobe       core data-access request
//   MemWrite        1 = store, 0 = load
//   ALUResult       byte address
//   WriteData       store data
//   ReadData        load data (latch register)
//   PCReady         core advance enable (combinational, 0 = stall)
//   mreq/mwe        memory request / write enable (registered)
//   maddr/mwdata    word address / store data (registered)
//   mrdata/mack     memory read data / completion pulse
//   err_clr         synchronous clear of buserr
//   buserr          sticky error flag
module mem_bridge #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemStrobe,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        PCReady,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack,
  input  logic        err_clr,
  output logic        buserr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mreq_q, mreq_d;
  logic          mwe_q, mwe_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          buserr_q, buserr_d;
  logic          err_set;
  logic          pcready_c;

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemStrobe) begin
          if (ALUResult[1:0] == 2'b00) begin
            state_d  = BUSY;
            mreq_d   = 1'b1;
            mwe_d    = MemWrite;
            maddr_d  = {ALUResult[31:2], 2'b00};
            mwdata_d = WriteData;
            cnt_d    = '0;
          end else begin
            // Misaligned: reject without a bus cycle.
            state_d = DONE;
            err_set = 1'b1;
            rdata_d = ERRDATA;
          end
        end
      end
      BUSY: begin
        // Saturating wait counter; never wraps.
        if (cnt_q < CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
        // mack takes priority over a coincident timeout.
        if (mack) begin
          if (!mwe_q) rdata_d = mrdata;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          err_set = 1'b1;
          rdata_d = ERRDATA;
          state_d = DONE;
        end
      end
      DONE: begin
        // MemStrobe here belongs to the retiring instruction.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        mreq_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase
    // Set wins over clear.
    if (err_set)      buserr_d = 1'b1;
    else if (err_clr) buserr_d = 1'b0;
    else              buserr_d = buserr_q;
  end

  // Core stall: first strobe cycle stalls, BUSY stalls, DONE releases.
  always_comb begin
    pcready_c = 1'b0;
    case (state_q)
      IDLE:    pcready_c = ~MemStrobe;
      BUSY:    pcready_c = 1'b0;
      DONE:    pcready_c = 1'b1;
      default: pcready_c = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
    end
  end

  assign ReadData = rdata_q;
  assign PCReady  = pcready_c;
  assign mreq     = mreq_q;
  assign mwe      = mwe_q;
  assign maddr    = maddr_q;
  assign mwdata   = mwdata_q;
  assign buserr   = buserr_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: self-checking bench for mem_bridge. A core/memory driver
// task runs one access and records what the bus and core port showed; each
// test pushes its expected outcome to a scoreboard queue and pops it when
// the access retires.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemStrobe, MemWrite, mack, err_clr;
  logic [31:0] ALUResult, WriteData, mrdata;
  logic [31:0] ReadData, maddr, mwdata;
  logic        PCReady, mreq, mwe, buserr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    int          cycles;
    int          mreq_cyc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Observations of the most recent access.
  int          obs_cycles, obs_mreq;
  logic [31:0] obs_maddr, obs_mwdata, obs_rd;
  logic        obs_mwe, obs_err;
  logic [2:0]  obs_pc;
  logic [31:0] exp_latch;

  mem_bridge dut (
    .clk(clk), .reset(reset), .MemStrobe(MemStrobe), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .PCReady(PCReady), .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mack(mack), .err_clr(err_clr), .buserr(buserr)
  );

  always #5 clk = ~clk;

  // Drive one access starting just after a rising edge; ack_at is the BUSY
  // cycle (1-based) that gets mack, 0 = never. Returns just after the edge
  // that retires the DONE cycle, with MemStrobe set to hold.
  task automatic run_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at,
                            input logic [31:0] mdata, input logic hold);
    int k = 0;
    int busy_idx = 0;
    bit done = 0;
    obs_cycles = 0; obs_mreq = 0; obs_maddr = 'x; obs_mwdata = 'x;
    obs_mwe = 1'bx; obs_rd = 'x; obs_err = 1'bx; obs_pc = 3'b111;
    MemStrobe = 1'b1; MemWrite = we; ALUResult = addr; WriteData = wdata;
    mack = 1'b0;
    while (!done && k < 40) begin
      if (mreq === 1'b1) begin
        busy_idx++;
        mack   = (busy_idx == ack_at);
        mrdata = mack ? mdata : $urandom();
      end else begin
        mack = 1'b0;
      end
      @(negedge clk);
      if (k < 3) obs_pc[2'(k)] = PCReady;
      if (mreq === 1'b1) begin
        obs_mreq++;
        obs_maddr = maddr; obs_mwe = mwe; obs_mwdata = mwdata;
      end
      if (k > 0 && PCReady === 1'b1) begin
        done = 1; obs_rd = ReadData; obs_err = buserr; obs_cycles = k + 1;
      end
      @(posedge clk); #1;
      mack = 1'b0;
      if (done) MemStrobe = hold;
      k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_bound: no DONE within 40 cycles, addr=%h", addr);
      MemStrobe = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; MemStrobe = 1'b0; MemWrite = 1'b0; ALUResult = '0;
    WriteData = '0; mrdata = '0; mack = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rst_mreq got=%b exp=0", mreq); end
    checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL rst_mwe got=%b exp=0", mwe); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL rst_maddr got=%h exp=0", maddr); end
    checks++; if (mwdata !== 32'h0) begin errors++; $display("FAIL rst_mwdata got=%h exp=0", mwdata); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", ReadData); end
    checks++; if (buserr !== 1'b0) begin errors++; $display("FAIL rst_buserr got=%b exp=0", buserr); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL idle_pcready got=%b exp=1", PCReady); end
    MemStrobe = 1'b1; #1;
    checks++; if (PCReady !== 1'b0) begin errors++; $display("FAIL idle_strobe_stall got=%b exp=0", PCReady); end
    MemStrobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    exp_t e;
    sb.push_back('{32'h12345678, 4, 2, 1'b0});
    run_access(1'b0, 32'h100, 32'h0, 2, 32'h12345678, 1'b0);
    e = sb.pop_front();
    exp_latch = e.rdata;
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL load_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_cycles != e.cycles) begin errors++; $display("FAIL load_cycles got=%0d exp=%0d", obs_cycles, e.cycles); end
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL load_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
    checks++; if (obs_maddr !== 32'h100) begin errors++; $display("FAIL load_maddr got=%h exp=100", obs_maddr); end
    checks++; if (obs_mwe !== 1'b0) begin errors++; $display("FAIL load_mwe got=%b exp=0", obs_mwe); end
    checks++; if (obs_err !== e.err) begin errors++; $display("FAIL load_buserr got=%b exp=%b", obs_err, e.err); end
  endtask

  task automatic test_store();
    exp_t e;
    sb.push_back('{exp_latch, 3, 1, 1'b0});
    run_access(1'b1, 32'h204, 32'hCAFEF00D, 1, 32'h55555555, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL store_latch got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL store_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
    checks++; if (obs_mwe !== 1'b1) begin errors++; $display("FAIL store_mwe got=%b exp=1", obs_mwe); end
    checks++; if (obs_mwdata !== 32'hCAFEF00D) begin errors++; $display("FAIL store_mwdata got=%h exp=cafef00d", obs_mwdata); end
    checks++; if (obs_maddr !== 32'h204) begin errors++; $display("FAIL store_maddr got=%h exp=204", obs_maddr); end
    checks++; if (obs_pc !== 3'b100) begin errors++; $display("FAIL store_pcready got=%b exp=100", obs_pc); end
    checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL store_mwe_drop got=%b exp=0", mwe); end
  endtask

  task automatic test_misaligned();
    exp_t e;
    sb.push_back('{32'hDEADBEEF, 2, 0, 1'b1});
    run_access(1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b0);
    e = sb.pop_front();
    exp_latch = e.rdata;
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL mis_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_cycles != e.cycles) begin errors++; $display("FAIL mis_cycles got=%0d exp=%0d", obs_cycles, e.cycles); end
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL mis_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
    checks++; if (obs_err !== e.err) begin errors++; $display("FAIL mis_buserr got=%b exp=%b", obs_err, e.err); end
    err_clr = 1'b1; @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (buserr !== 1'b0) begin errors++; $display("FAIL mis_errclr got=%b exp=0", buserr); end
    @(posedge clk); #1;
    // err_clr coincident with the set: set must win.
    err_clr = 1'b1;
    run_access(1'b1, 32'h3, 32'h0, 0, 32'h0, 1'b0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr got=%b exp=1", obs_err); end
    err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{32'hDEADBEEF, 17, 15, 1'b1});
    run_access(1'b0, 32'h800, 32'h0, 0, 32'h0, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL to_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
    checks++; if (obs_cycles != e.cycles) begin errors++; $display("FAIL to_cycles got=%0d exp=%0d", obs_cycles, e.cycles); end
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL to_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_err !== e.err) begin errors++; $display("FAIL to_buserr got=%b exp=%b", obs_err, e.err); end
    @(negedge clk);
    checks++; if (buserr !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", buserr); end
    @(posedge clk); #1 err_clr = 1'b1; @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (buserr !== 1'b0) begin errors++; $display("FAIL to_errclr got=%b exp=0", buserr); end
    @(posedge clk); #1;
    // mack on the last allowed BUSY cycle beats the timeout.
    sb.push_back('{32'hA5A55A5A, 17, 15, 1'b0});
    run_access(1'b0, 32'h804, 32'h0, 15, 32'hA5A55A5A, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL race_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_err !== e.err) begin errors++; $display("FAIL race_buserr got=%b exp=%b", obs_err, e.err); end
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL race_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
  endtask

  task automatic test_reset_mid_busy();
    MemStrobe = 1'b1; MemWrite = 1'b0; ALUResult = 32'h300;
    @(posedge clk); #1;
    checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL rb_mreq_up got=%b exp=1", mreq); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rb_async_mreq got=%b exp=0", mreq); end
    @(posedge clk); #1;
    reset = 1'b1; MemStrobe = 1'b0; mack = 1'b1; mrdata = 32'h77777777;
    @(negedge clk);
    checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL rb_pcready got=%b exp=1", PCReady); end
    @(posedge clk); #1 mack = 1'b0;
    @(negedge clk);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rb_mack_ignored got=%h exp=0", ReadData); end
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL rb_mreq_idle got=%b exp=0", mreq); end
    checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL rb_idle got=%b exp=1", PCReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int extra = 0;
    sb.push_back('{32'h11111111, 3, 1, 1'b0});
    sb.push_back('{32'h22222222, 3, 1, 1'b0});
    run_access(1'b0, 32'h400, 32'h0, 1, 32'h11111111, 1'b1);
    e = sb.pop_front();
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL b2b1_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_mreq != e.mreq_cyc) begin errors++; $display("FAIL b2b1_mreq got=%0d exp=%0d", obs_mreq, e.mreq_cyc); end
    run_access(1'b0, 32'h404, 32'h0, 1, 32'h22222222, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_rd !== e.rdata) begin errors++; $display("FAIL b2b2_rdata got=%h exp=%h", obs_rd, e.rdata); end
    checks++; if (obs_cycles != e.cycles) begin errors++; $display("FAIL b2b2_cycles got=%0d exp=%0d", obs_cycles, e.cycles); end
    checks++; if (obs_maddr !== 32'h404) begin errors++; $display("FAIL b2b2_maddr got=%h exp=404", obs_maddr); end
    repeat (3) begin
      @(negedge clk); if (mreq !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_access got=%0d exp=0", extra); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 15, means the maximum BUSY cycles to wait for mack before aborting.
REQ-002 Parameter ERRDATA, default 32'hDEADBEEF, means the ReadData value returned on an aborted or misaligned load.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 MemStrobe  in  1  core requests a data access this cycle.
REQ-006 MemWrite  in  1  1 = store, 0 = load; qualified by MemStrobe.
REQ-007 ALUResult  in  32  byte address from core.
REQ-008 WriteData  in  32  store data from core.
REQ-009 ReadData  out  32  load data to core.
REQ-010 PCReady  out  1  core PC/instruction advance enable; 0 = stall.
REQ-011 mreq  out  1  memory request, registered.
REQ-012 mwe  out  1  memory write enable, registered.
REQ-013 maddr  out  32  word address {addr[31:2],2'b00}, registered.
REQ-014 mwdata  out  32  store data, registered.
REQ-015 mrdata  in  32  memory read data, valid with mack.
REQ-016 mack  in  1  memory completion, single-cycle pulse.
REQ-017 err_clr  in  1  synchronous clear of buserr.
REQ-018 buserr  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-020 In IDLE, PCReady SHALL equal ~MemStrobe combinationally, so the first strobe cycle stalls the core.
REQ-021 In IDLE with MemStrobe and ALUResult[1:0]==0, the block SHALL latch address, data and MemWrite, and go to BUSY with mreq=1 next cycle.
REQ-022 In IDLE with MemStrobe and ALUResult[1:0]!=0, the block SHALL go to DONE, set buserr, issue no mreq, and load ReadData latch with ERRDATA.
REQ-023 In BUSY, PCReady SHALL be 0, mreq/mwe/maddr/mwdata SHALL stay constant, and the wait counter SHALL increment each cycle.
REQ-024 In BUSY with mack=1, the block SHALL latch mrdata (loads only; stores keep prior latch), drop mreq, and go to DONE.
REQ-025 In BUSY with no mack and the counter equal to TIMEOUT-1, the block SHALL drop mreq, set buserr, load the latch with ERRDATA, and go to DONE.
REQ-026 mack and timeout in the same cycle: mack SHALL win; no error.
REQ-027 In DONE, PCReady SHALL be 1, ReadData SHALL present the latch, and next state SHALL be IDLE unconditionally; MemStrobe in DONE SHALL be ignored, since it belongs to the retiring instruction.
REQ-028 ReadData SHALL always drive the latch register; its value outside DONE is don't-care to the core.
REQ-029 Minimum occupancy of a memory instruction SHALL be 3 cycles (IDLE, BUSY with mack, DONE); a non-memory instruction SHALL take 1 cycle.
REQ-030 mack outside BUSY SHALL be ignored with no state or data change.
REQ-031 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on entry to BUSY, and never wrap.
REQ-032 buserr SHALL stay set until err_clr=1; if set and clear occur in the same cycle, set SHALL win.

Reset
REQ-033 reset low SHALL immediately force: state IDLE, mreq 0, mwe 0, maddr 0, mwdata 0, latch 0, counter 0, buserr 0.
REQ-034 reset asserted mid-BUSY SHALL abort the access with no DONE cycle; mreq SHALL fall asynchronously.
REQ-035 After reset release, PCReady SHALL follow REQ-020.

Verification
REQ-036 Load, addr 0x100, mack on 2nd BUSY cycle with mrdata 0x12345678 -> mreq high 2 cycles, maddr 0x100, mwe 0; DONE ReadData 0x12345678 with PCReady 1; 4 cycles total.
REQ-037 Store, addr 0x204, data 0xCAFEF00D, mack 1st BUSY cycle -> mwe 1, mwdata 0xCAFEF00D for 1 cycle; PCReady 0,0,1.
REQ-038 Load, addr 0x102 -> no mreq; buserr 1; DONE ReadData 0xDEADBEEF; 2 cycles.
REQ-039 Load with mack never asserted -> mreq high exactly 15 cycles; buserr 1; ReadData 0xDEADBEEF; err_clr pulse -> buserr 0.
REQ-040 Reset low during BUSY, then mack pulse after release -> mreq 0 immediately, state IDLE, mack ignored, PCReady 1 with MemStrobe 0.
REQ-041 Back-to-back loads, MemStrobe held high through DONE -> exactly two BUSY sequences, no extra access from the DONE cycle.
